// File: rtl/adc_serial_rx_pkg.sv
// rtl/adc_serial_rx_pkg.sv - shared constants and FSM state encoding for the serial ADC reader
package adc_rx_pkg;

    localparam int ADC_DATA_W      = 12;
    localparam int ADC_FRAME_BITS  = 16;
    localparam int ADC_QUIET_EDGES = 2;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        SHIFT = 3'd2,
        DONE  = 3'd3,
        QUIET = 3'd4
    } rx_state_t;

endpackage

// File: rtl/adc_serial_rx_if.sv
// rtl/adc_serial_rx_if.sv - sample/status bundle from the ADC reader to the equalizer datapath
interface adc_serial_rx_if #(
    parameter int DATA_W = 12
);
    logic [DATA_W-1:0] sample_o;
    logic              valid_o;
    logic              busy_o;
    logic              frame_err_o;

    modport master (output sample_o, valid_o, busy_o, frame_err_o);
    modport slave  (input  sample_o, valid_o, busy_o, frame_err_o);
endinterface

// File: rtl/adc_serial_rx_sclk_edge_det.sv
// rtl/adc_serial_rx_sclk_edge_det.sv - single-cycle rise/fall strobes for a clk_i-domain divided clock
module sclk_edge_det (
    input  logic clk_i,
    input  logic rst_i,
    input  logic sclk_i,
    output logic rise_o,
    output logic fall_o
);
    logic sclk_q;

    // Loading the live level during reset keeps the first post-reset cycle edge-free.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sclk_q <= sclk_i;
        end else begin
            sclk_q <= sclk_i;
        end
    end

    assign rise_o = sclk_i & ~sclk_q;
    assign fall_o = ~sclk_i & sclk_q;
endmodule

// File: rtl/adc_serial_rx.sv
// rtl/adc_serial_rx.sv - framed MSB-first serial ADC reader; ADC_SIGNED_EN selects two's-complement samples
import adc_rx_pkg::*;

module adc_serial_rx #(
    parameter int DATA_W      = ADC_DATA_W,
    parameter int FRAME_BITS  = ADC_FRAME_BITS,
    parameter int QUIET_EDGES = ADC_QUIET_EDGES
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             sclk_i,
    input  logic             sdata_i,
    output logic             cs_n_o,
    adc_serial_rx_if.master  smp
);
    localparam int CNT_W  = $clog2(FRAME_BITS + 1);
    localparam int QCNT_W = $clog2(QUIET_EDGES + 1);

    rx_state_t             state;
    logic [CNT_W-1:0]      bit_cnt;
    logic [QCNT_W-1:0]     quiet_cnt;
    logic [FRAME_BITS-1:0] shreg;
    logic [DATA_W-1:0]     sample_next;
    logic                  sdata_meta;
    logic                  sdata_sync;
    logic                  rise;
    logic                  fall;

    sclk_edge_det u_edge (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .sclk_i (sclk_i),
        .rise_o (rise),
        .fall_o (fall)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sdata_meta <= 1'b0;
            sdata_sync <= 1'b0;
        end else begin
            sdata_meta <= sdata_i;
            sdata_sync <= sdata_meta;
        end
    end

`ifdef ADC_SIGNED_EN
    // Offset-binary to two's complement for the signed filter bank.
    assign sample_next = {~shreg[DATA_W-1], shreg[DATA_W-2:0]};
`else
    assign sample_next = shreg[DATA_W-1:0];
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state           <= IDLE;
            bit_cnt         <= '0;
            quiet_cnt       <= '0;
            shreg           <= '0;
            cs_n_o          <= 1'b1;
            smp.sample_o    <= '0;
            smp.valid_o     <= 1'b0;
            smp.busy_o      <= 1'b0;
            smp.frame_err_o <= 1'b0;
        end else begin
            smp.valid_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (en_i) state <= START;
                end
                START: begin
                    if (fall) begin
                        cs_n_o     <= 1'b0;
                        smp.busy_o <= 1'b1;
                        bit_cnt    <= '0;
                        state      <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (rise) begin
                        shreg   <= {shreg[FRAME_BITS-2:0], sdata_sync};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == CNT_W'(FRAME_BITS - 1)) state <= DONE;
                    end
                end
                DONE: begin
                    if (fall) begin
                        cs_n_o          <= 1'b1;
                        smp.busy_o      <= 1'b0;
                        smp.sample_o    <= sample_next;
                        smp.valid_o     <= 1'b1;
                        smp.frame_err_o <= smp.frame_err_o | (|shreg[FRAME_BITS-1:DATA_W]);
                        quiet_cnt       <= '0;
                        state           <= QUIET;
                    end
                end
                QUIET: begin
                    // en_i is only honoured once the inter-frame gap has elapsed.
                    if (rise) begin
                        if (quiet_cnt == QCNT_W'(QUIET_EDGES - 1)) begin
                            quiet_cnt <= '0;
                            state     <= en_i ? START : IDLE;
                        end else begin
                            quiet_cnt <= quiet_cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_adc_serial_rx.sv
// tb/tb_adc_serial_rx.sv - randomized ADC-model bench for adc_serial_rx with a frame-level scoreboard
module tb_adc_serial_rx;
    localparam int HALF       = 67;
    localparam int FRAME_BITS = 16;
    localparam int PERIOD     = 2 * HALF;

    logic clk = 1'b0;
    logic rst, en, sclk, sdata, cs_n;
    logic sclk_run;
    int   hcnt;

    adc_serial_rx_if #(.DATA_W(12)) smp ();

    adc_serial_rx dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .en_i    (en),
        .sclk_i  (sclk),
        .sdata_i (sdata),
        .cs_n_o  (cs_n),
        .smp     (smp.master)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [11:0] exp_sample(input logic [15:0] w);
`ifdef ADC_SIGNED_EN
        return {~w[11], w[10:0]};
`else
        return w[11:0];
`endif
    endfunction

    logic [15:0] tx_q[$];
    logic [15:0] exp_q[$];
    logic        err_model;
    int          starts, valids, rise_cnt;

    initial begin
        sclk = 1'b1;
        hcnt = 0;
        forever begin
            @(posedge clk);
            #1;
            if (sclk_run) begin
                hcnt++;
                if (hcnt >= HALF) begin
                    hcnt = 0;
                    sclk = ~sclk;
                end
            end
        end
    end

    // ADC model plus scoreboard: shifts each word out MSB-first, data changes on sclk fall.
    initial begin
        logic        prev_cs, prev_sclk, prev_valid;
        logic [15:0] cur, w;
        int          idx;
        prev_cs = 1'b1; prev_sclk = 1'b1; prev_valid = 1'b0;
        idx = -1; cur = '0; sdata = 1'b0; err_model = 1'b0;
        starts = 0; valids = 0; rise_cnt = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_cs = 1'b1; prev_sclk = sclk; prev_valid = 1'b0; idx = -1;
            end else begin
                if (prev_cs && !cs_n) begin
                    starts++;
                    rise_cnt = 0;
                    cur = (tx_q.size() > 0) ? tx_q.pop_front() : {4'h0, 12'($urandom)};
                    exp_q.push_back(cur);
                    idx = FRAME_BITS - 1;
                end else if (!cs_n && prev_sclk && !sclk) begin
                    idx--;
                end
                if (!cs_n && sclk && !prev_sclk) rise_cnt++;
                if (cs_n && !prev_cs) check("cs_low_rises", rise_cnt, FRAME_BITS);
                if (cs_n) idx = -1;
                if (smp.valid_o) begin
                    valids++;
                    if (prev_valid) check("valid_width", 2, 1);
                    if (exp_q.size() == 0) begin
                        check("unexpected_valid", 1, 0);
                    end else begin
                        w = exp_q.pop_front();
                        err_model = err_model | (w[15:12] != 4'h0);
                        check("sample", smp.sample_o, exp_sample(w));
                        check("frame_err", smp.frame_err_o, err_model);
                        check("valid_cs_n", cs_n, 1);
                    end
                end
                prev_cs = cs_n; prev_sclk = sclk; prev_valid = smp.valid_o;
            end
            sdata = (idx >= 0) ? cur[idx] : 1'($urandom_range(0, 1));
        end
    end

    task automatic wait_valids(input int target, input int budget);
        int n = 0;
        while (valids < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (valids < target) check("valid_timeout", valids, target);
    endtask

    task automatic wait_bit(input int bitn, input int budget);
        int n = 0;
        while (!(cs_n == 1'b0 && rise_cnt == bitn) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) check("bit_timeout", rise_cnt, bitn);
    endtask

    task automatic idle_wait(input int periods);
        repeat (periods * PERIOD) @(negedge clk);
    endtask

    initial begin
        int s0, v0, n;
        rst = 1'b1; en = 1'b0; sclk_run = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("rst_cs_n", cs_n, 1);
        check("rst_sample", smp.sample_o, 0);
        check("rst_valid", smp.valid_o, 0);
        check("rst_busy", smp.busy_o, 0);
        check("rst_err", smp.frame_err_o, 0);
        @(posedge clk); #1 rst = 1'b0;

        // continuous frames: fixed patterns, leading-bit error, signed boundaries, random words
        tx_q.push_back(16'h0A5C); tx_q.push_back(16'h0A5C);
        tx_q.push_back(16'h8001); tx_q.push_back(16'h0A5C);
        tx_q.push_back(16'h0800); tx_q.push_back(16'h0000);
        tx_q.push_back(16'h0FFF);
        repeat (5) tx_q.push_back({4'h0, 12'($urandom)});
        n = tx_q.size();
        @(posedge clk); #1 en = 1'b1;
        wait_valids(n, (n + 2) * 20 * PERIOD);
        check("err_sticky", smp.frame_err_o, 1);

        @(posedge clk); #1 en = 1'b0;
        idle_wait(22);
        check("idle_cs_n", cs_n, 1);
        check("idle_busy", smp.busy_o, 0);

        // single-cycle enable pulse while idle
        s0 = starts; v0 = valids;
        @(posedge clk); #1 en = 1'b1;
        @(posedge clk); #1 en = 1'b0;
        idle_wait(25);
        check("pulse_starts", starts - s0, 1);
        check("pulse_valids", valids - v0, 1);
        check("pulse_cs_n", cs_n, 1);

        // enable dropped at bit 5
        s0 = starts; v0 = valids;
        @(posedge clk); #1 en = 1'b1;
        wait_bit(5, 25 * PERIOD);
        @(posedge clk); #1 en = 1'b0;
        idle_wait(25);
        check("drop_starts", starts - s0, 1);
        check("drop_valids", valids - v0, 1);

        // reset at bit 9
        @(posedge clk); #1 en = 1'b1;
        wait_bit(9, 25 * PERIOD);
        v0 = valids;
        @(posedge clk); #1 rst = 1'b1;
        exp_q.delete();
        err_model = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("mid_rst_cs_n", cs_n, 1);
        check("mid_rst_busy", smp.busy_o, 0);
        check("mid_rst_sample", smp.sample_o, 0);
        check("mid_rst_valid", smp.valid_o, 0);
        check("mid_rst_err", smp.frame_err_o, 0);
        @(posedge clk); #1 rst = 1'b0;
        n = 0;
        while (sclk == 1'b1 && n < 2 * PERIOD) begin @(negedge clk); n++; end
        while (sclk == 1'b0 && n < 2 * PERIOD) begin @(negedge clk); n++; end
        while (sclk == 1'b1 && n < 2 * PERIOD) begin @(negedge clk); n++; end
        repeat (3) @(negedge clk);
        check("post_rst_first_fall_cs_n", cs_n, 0);
        check("post_rst_no_valid", valids, v0);
        wait_valids(v0 + 1, 25 * PERIOD);

        // sclk held high through reset release
        n = 0;
        while (sclk != 1'b1 && n < 2 * PERIOD) begin @(negedge clk); n++; end
        sclk_run = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        exp_q.delete();
        err_model = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        v0 = valids;
        repeat (200) @(negedge clk);
        check("stall_cs_n", cs_n, 1);
        check("stall_busy", smp.busy_o, 0);
        check("stall_valids", valids, v0);
        hcnt = 0;
        sclk_run = 1'b1;
        wait_valids(v0 + 1, 25 * PERIOD);
        @(posedge clk); #1 en = 1'b0;
        idle_wait(4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
